// File: rtl/wb_unit_pkg.sv
// rtl/wb_unit_pkg.sv - shared types for the writeback unit
package wb_unit_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_CSR  = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LD  = 3'b011,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101,
        LD_LWU = 3'b110,
        LD_RSV = 3'b111
    } ld_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // MEM-stage fields held while a load waits; offset is sized for XLEN=64
    typedef struct packed {
        logic [4:0] rd;
        logic       rf_en;
        ld_type_e   ld_type;
        logic [2:0] offset;
    } wb_unit_in_t;

endpackage

// File: rtl/wb_unit_if.sv
// rtl/wb_unit_if.sv - MEM-stage, data-memory response and register-file write bundle
interface wb_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] opr_res;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] csr_rdata;
    logic [4:0]      rd;
    logic            rf_en;
    logic [1:0]      wb_sel;
    logic [2:0]      ld_type;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            load_err;
    logic            busy;

    modport master (
        output in_valid, opr_res, pc_plus4, csr_rdata, rd, rf_en, wb_sel, ld_type,
               dmem_rvalid, dmem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, load_err, busy
    );

    modport slave (
        input  in_valid, opr_res, pc_plus4, csr_rdata, rd, rf_en, wb_sel, ld_type,
               dmem_rvalid, dmem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, load_err, busy
    );
endinterface

// File: rtl/wb_unit_load_align.sv
// rtl/wb_unit_load_align.sv - lane select and sign/zero extension of load data
module load_align
    import wb_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      offset,
    input  ld_type_e        ld_type,
    output logic [XLEN-1:0] res
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;

    // offset[0] is ignored for halves and offset[1:0] for words; misalignment traps upstream
    always_comb begin
        b = data[8 * int'(offset) +: 8];
        h = data[16 * int'(offset[2:1]) +: 16];
        w = data[32 * int'(offset[2]) +: 32];
        res = data;
        case (ld_type)
            LD_LB:  begin res = {XLEN{b[7]}};  res[7:0]  = b; end
            LD_LBU: begin res = '0;            res[7:0]  = b; end
            LD_LH:  begin res = {XLEN{h[15]}}; res[15:0] = h; end
            LD_LHU: begin res = '0;            res[15:0] = h; end
            LD_LW:  begin res = {XLEN{w[31]}}; res[31:0] = w; end
            LD_LWU: begin res = '0;            res[31:0] = w; end
            default: res = data;
        endcase
    end
endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback stage: source select, load wait with timeout, registered RF port
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic     clk,
    input  logic     rst,
    wb_unit_if.slave bus
);
    localparam int OW = $clog2(XLEN / 8);
    localparam int CW = $clog2(LOAD_TIMEOUT + 1);

    state_e          state, state_nxt;
    logic [CW-1:0]   cnt;
    wb_unit_in_t     pend;
    logic            rf_we_q, load_err_q;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;

    logic            in_ready, busy, xfer, is_load, timeout;
    logic [2:0]      cur_off, al_off;
    ld_type_e        al_type;
    logic [XLEN-1:0] al_data, src;

    assign xfer    = bus.in_valid && in_ready;
    assign is_load = (wb_sel_e'(bus.wb_sel) == WB_LOAD);
    assign timeout = (cnt == CW'(LOAD_TIMEOUT - 1));
    assign cur_off = 3'(bus.opr_res[OW-1:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && is_load && !bus.dmem_rvalid) state_nxt = WAIT;
            WAIT:    if (bus.dmem_rvalid || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == WAIT);
    end

    // While waiting, align with the captured offset/type rather than the live MEM inputs
    assign al_off  = (state == WAIT) ? pend.offset  : cur_off;
    assign al_type = (state == WAIT) ? pend.ld_type : ld_type_e'(bus.ld_type);

    load_align #(.XLEN(XLEN)) u_align (
        .data    (bus.dmem_rdata),
        .offset  (al_off),
        .ld_type (al_type),
        .res     (al_data)
    );

    always_comb begin
        src = bus.opr_res;
        case (wb_sel_e'(bus.wb_sel))
            WB_ALU:  src = bus.opr_res;
            WB_LOAD: src = al_data;
            WB_PC4:  src = bus.pc_plus4;
            default: src = bus.csr_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            load_err_q <= 1'b0;
            cnt        <= '0;
            pend       <= '0;
        end else begin
            rf_we_q    <= 1'b0;
            load_err_q <= 1'b0;
            if (xfer) begin
                if (!is_load || bus.dmem_rvalid) begin
                    rf_we_q    <= bus.rf_en && (bus.rd != 5'd0);
                    rf_waddr_q <= bus.rd;
                    rf_wdata_q <= src;
                end else begin
                    pend <= '{rd: bus.rd, rf_en: bus.rf_en,
                              ld_type: ld_type_e'(bus.ld_type), offset: cur_off};
                    cnt  <= '0;
                end
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (bus.dmem_rvalid) begin
                    rf_we_q    <= pend.rf_en && (pend.rd != 5'd0);
                    rf_waddr_q <= pend.rd;
                    rf_wdata_q <= al_data;
                end else if (timeout) begin
                    load_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = busy;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - directed and random checks of wb_unit at XLEN 32 and 64
module tb_wb_unit;
    import wb_unit_pkg::*;

    localparam int T32 = 4;
    localparam int T64 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_unit_if #(.XLEN(32)) b32 ();
    wb_unit_if #(.XLEN(64)) b64 ();

    wb_unit #(.XLEN(32), .LOAD_TIMEOUT(T32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    wb_unit #(.XLEN(64), .LOAD_TIMEOUT(T64)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] o_rdy(int w);
        return (w == 64) ? 64'(b64.in_ready) : 64'(b32.in_ready);
    endfunction
    function automatic logic [63:0] o_we(int w);
        return (w == 64) ? 64'(b64.rf_we) : 64'(b32.rf_we);
    endfunction
    function automatic logic [63:0] o_waddr(int w);
        return (w == 64) ? 64'(b64.rf_waddr) : 64'(b32.rf_waddr);
    endfunction
    function automatic logic [63:0] o_wdata(int w);
        return (w == 64) ? b64.rf_wdata : 64'(b32.rf_wdata);
    endfunction
    function automatic logic [63:0] o_err(int w);
        return (w == 64) ? 64'(b64.load_err) : 64'(b32.load_err);
    endfunction
    function automatic logic [63:0] o_busy(int w);
        return (w == 64) ? 64'(b64.busy) : 64'(b32.busy);
    endfunction

    // Reference: pick the naturally aligned lane of the access size, then extend
    function automatic logic [63:0] ref_load(int w, logic [63:0] d, logic [63:0] addr, logic [2:0] t);
        int size, lane;
        bit sgn;
        logic [63:0] v, m, xm;
        xm = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        d = d & xm;
        sgn = (t[2] == 1'b0);
        case (t)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            3'd6:       size = (w == 64) ? 4 : 0;
            default:    size = 0;
        endcase
        if (size == 0) return d;
        lane = (int'(addr[2:0]) % (w / 8)) / size * size;
        v = d >> (8 * lane);
        m = (64'd1 << (8 * size)) - 64'd1;
        v = v & m;
        if (sgn && v[8 * size - 1]) v = v | ~m;
        return v & xm;
    endfunction

    task automatic set_ctl(int w, logic v, logic rv);
        if (w == 64) begin b64.in_valid = v; b64.dmem_rvalid = rv; end
        else         begin b32.in_valid = v; b32.dmem_rvalid = rv; end
    endtask

    task automatic drive(int w, logic v, logic [1:0] sel, logic [2:0] lt, logic [63:0] opr,
                         logic [63:0] pc, logic [63:0] csr, logic [4:0] rd, logic en,
                         logic rv, logic [63:0] data);
        if (w == 64) begin
            b64.opr_res = opr; b64.pc_plus4 = pc; b64.csr_rdata = csr; b64.dmem_rdata = data;
            b64.rd = rd; b64.rf_en = en; b64.wb_sel = sel; b64.ld_type = lt;
        end else begin
            b32.opr_res = opr[31:0]; b32.pc_plus4 = pc[31:0]; b32.csr_rdata = csr[31:0];
            b32.dmem_rdata = data[31:0];
            b32.rd = rd; b32.rf_en = en; b32.wb_sel = sel; b32.ld_type = lt;
        end
        set_ctl(w, v, rv);
    endtask

    // dly: 0 = response with the transfer, >0 = response that many cycles later, <0 = none
    task automatic txn(int w, logic [1:0] sel, logic [2:0] lt, logic [63:0] opr, logic [63:0] data,
                       logic [4:0] rd, logic en, int dly, string tag);
        int tmo;
        logic [63:0] xm, pc, csr, exp;
        logic exp_we;
        tmo = (w == 64) ? T64 : T32;
        xm  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        pc  = {$urandom, $urandom};
        csr = {$urandom, $urandom};
        case (sel)
            2'd0:    exp = opr;
            2'd1:    exp = ref_load(w, data, opr, lt);
            2'd2:    exp = pc;
            default: exp = csr;
        endcase
        exp = exp & xm;
        exp_we = en && (rd != 5'd0);
        chk({tag, ":accept"}, o_rdy(w), 64'd1);
        drive(w, 1'b1, sel, lt, opr, pc, csr, rd, en, (sel == 2'd1 && dly == 0), data);
        tick();
        set_ctl(w, 1'b0, 1'b0);
        if (sel == 2'd1 && dly > 0) begin
            for (int k = 1; k < dly; k++) begin
                chk({tag, ":wait_rdy"}, o_rdy(w), 64'd0);
                chk({tag, ":wait_we"}, o_we(w), 64'd0);
                tick();
            end
            chk({tag, ":wait_busy"}, o_busy(w), 64'd1);
            set_ctl(w, 1'b0, 1'b1);
            tick();
            set_ctl(w, 1'b0, 1'b0);
        end else if (sel == 2'd1 && dly < 0) begin
            for (int k = 1; k <= tmo; k++) begin
                chk({tag, ":tmo_rdy"}, o_rdy(w), 64'd0);
                chk({tag, ":tmo_err_early"}, o_err(w), 64'd0);
                tick();
            end
            chk({tag, ":tmo_err"}, o_err(w), 64'd1);
            chk({tag, ":tmo_we"}, o_we(w), 64'd0);
            chk({tag, ":tmo_rdy_back"}, o_rdy(w), 64'd1);
            return;
        end
        chk({tag, ":we"}, o_we(w), 64'(exp_we));
        chk({tag, ":waddr"}, o_waddr(w), 64'(rd));
        chk({tag, ":wdata"}, o_wdata(w), exp);
        chk({tag, ":err"}, o_err(w), 64'd0);
        chk({tag, ":rdy"}, o_rdy(w), 64'd1);
    endtask

    initial begin
        drive(32, 1'b0, 2'd0, 3'd0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0);
        drive(64, 1'b0, 2'd0, 3'd0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0);
        rst = 1'b1;
        tick();
        tick();
        for (int w = 32; w <= 64; w += 32) begin
            chk("rst_we", o_we(w), 64'd0);
            chk("rst_waddr", o_waddr(w), 64'd0);
            chk("rst_wdata", o_wdata(w), 64'd0);
            chk("rst_err", o_err(w), 64'd0);
            chk("rst_busy", o_busy(w), 64'd0);
            chk("rst_rdy", o_rdy(w), 64'd1);
        end
        rst = 1'b0;
        tick();

        txn(32, 2'd0, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b1, 0, "alu");
        chk("alu_const", o_wdata(32), 64'h0000_1234);
        txn(32, 2'd1, LD_LB, 64'h3, 64'h80FF_FF7F, 5'd6, 1'b1, 0, "lb");
        chk("lb_const", o_wdata(32), 64'hFFFF_FF80);
        txn(32, 2'd1, LD_LBU, 64'h3, 64'h80FF_FF7F, 5'd6, 1'b1, 0, "lbu");
        chk("lbu_const", o_wdata(32), 64'h0000_0080);
        txn(32, 2'd1, LD_LH, 64'h2, 64'h8001_0000, 5'd7, 1'b1, 4, "lh_late");
        chk("lh_const", o_wdata(32), 64'hFFFF_8001);
        txn(32, 2'd1, LD_LW, 64'h0, 64'h1111_2222, 5'd9, 1'b1, -1, "tmo");
        txn(32, 2'd2, 3'd0, 64'd0, 64'd0, 5'd10, 1'b1, 0, "after_tmo");
        chk("tmo_single_pulse", o_err(32), 64'd0);
        txn(32, 2'd1, LD_LW, 64'h0, 64'hDEAD_BEEF, 5'd0, 1'b1, 0, "ld_rd0");
        txn(32, 2'd0, 3'd0, 64'h55, 64'd0, 5'd4, 1'b0, 0, "alu_noen");
        chk("noen_we", o_we(32), 64'd0);

        set_ctl(32, 1'b0, 1'b1);
        tick();
        set_ctl(32, 1'b0, 1'b0);
        chk("idle_rvalid_we", o_we(32), 64'd0);
        chk("idle_rvalid_busy", o_busy(32), 64'd0);

        txn(64, 2'd1, LD_LW, 64'h4, 64'h8000_0001_1234_5678, 5'd3, 1'b1, 0, "lw64");
        chk("lw64_const", o_wdata(64), 64'hFFFF_FFFF_8000_0001);
        txn(64, 2'd1, LD_LWU, 64'h4, 64'h8000_0001_1234_5678, 5'd3, 1'b1, 2, "lwu64");
        chk("lwu64_const", o_wdata(64), 64'h0000_0000_8000_0001);
        txn(64, 2'd1, LD_LD, 64'h0, 64'hFEDC_BA98_7654_3210, 5'd8, 1'b1, T64, "ld64_edge");

        for (int w = 32; w <= 64; w += 32) begin
            for (int i = 0; i < 40; i++) begin
                int r, dly;
                r = int'($urandom_range(0, 9));
                dly = (r == 0) ? -1 : (r < 5) ? 0 : int'($urandom_range(1, (w == 64) ? T64 : T32));
                txn(w, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
                    {$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    dly, "rnd");
            end
        end

        drive(64, 1'b1, 2'd1, LD_LW, 64'h0, 64'd0, 64'd0, 5'd12, 1'b1, 1'b0, 64'hABCD);
        tick();
        set_ctl(64, 1'b0, 1'b0);
        tick();
        chk("rstw_busy_before", o_busy(64), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_busy", o_busy(64), 64'd0);
        chk("rstw_we", o_we(64), 64'd0);
        chk("rstw_err", o_err(64), 64'd0);
        chk("rstw_rdy", o_rdy(64), 64'd1);
        set_ctl(64, 1'b0, 1'b1);
        tick();
        set_ctl(64, 1'b0, 1'b0);
        chk("rstw_stale_we", o_we(64), 64'd0);
        chk("rstw_stale_err", o_err(64), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
